// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: video timing sequencer for a DVI/TMDS transmitter.
// It generates programmable horizontal and vertical timing and fetches pixels
// from an upstream FIFO using a request/valid handshake. Fetched data is kept
// aligned with HS, VS and DE on the transmitter bus.
//
// Enable and disable take effect only at frame boundaries. When the source
// underflows, a black pixel is sent in place of the missing one and a sticky
// flag is set.
//
// Ports:
//   CLK           pixel clock
//   RESET         asynchronous active-high reset
//   ENABLE        run request (level-sensitive)
//   PIX_REQ       pixel request to the source (stage 1)
//   PIX_VALID     source has a pixel on PIX_RGB while PIX_REQ is high
//   PIX_RGB       {R,G,B} pixel from the source
//   TX_RED/GRN/BLU, TX_HS, TX_VS, TX_DE   transmitter bus (stage 2)
//   FRAME_START   one-cycle pulse with output pixel (0,0)
//   BUSY          sequencer not idle
//   UNDERFLOW     sticky source-underflow flag
//   UNDERFLOW_CLR clears UNDERFLOW; a simultaneous set takes priority
module dvi_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_ACT   = 1'b0,
  parameter logic        VS_ACT   = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic        PIX_REQ,
  input  logic        PIX_VALID,
  input  logic [23:0] PIX_RGB,
  output logic [7:0]  TX_RED,
  output logic [7:0]  TX_GRN,
  output logic [7:0]  TX_BLU,
  output logic        TX_HS,
  output logic        TX_VS,
  output logic        TX_DE,
  output logic        FRAME_START,
  output logic        BUSY,
  output logic        UNDERFLOW,
  input  logic        UNDERFLOW_CLR
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYN_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // stage-1 decode registers (PIX_REQ doubles as stage-1 de)
  logic s1_hs;
  logic s1_vs;
  logic s1_fs;

  logic running_c;
  logic frame_last_c;
  logic h_last_c;
  logic v_last_c;
  logic underflow_set_c;

  assign running_c       = (state != ST_IDLE);
  assign h_last_c        = (h_cnt == H_LAST);
  assign v_last_c        = (v_cnt == V_LAST);
  assign frame_last_c    = h_last_c && v_last_c;
  assign underflow_set_c = PIX_REQ && !PIX_VALID;

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state: STOP keeps the frame running until its last pixel
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ENABLE) next_state = ST_RUN;
      ST_RUN:  if (!ENABLE) next_state = ST_STOP;
      ST_STOP: begin
        if (ENABLE) begin
          next_state = ST_RUN;
        end else if (frame_last_c) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // BUSY tracks the state register exactly, but as a flop of its own
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BUSY <= 1'b0;
    end else begin
      BUSY <= (next_state != ST_IDLE);
    end
  end

  // stage 0: raster counters, held at origin while idle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running_c) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // stage 1: request and sync decode from the counter value
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PIX_REQ <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_fs   <= 1'b0;
    end else begin
      PIX_REQ <= running_c && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      s1_hs   <= running_c && (h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END);
      s1_vs   <= running_c && (v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END);
      s1_fs   <= running_c && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // stage 2: transmitter bus, data captured in the same cycle as DE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TX_DE       <= 1'b0;
      TX_HS       <= ~HS_ACT;
      TX_VS       <= ~VS_ACT;
      FRAME_START <= 1'b0;
      TX_RED      <= '0;
      TX_GRN      <= '0;
      TX_BLU      <= '0;
    end else begin
      TX_DE       <= PIX_REQ;
      TX_HS       <= s1_hs ? HS_ACT : ~HS_ACT;
      TX_VS       <= s1_vs ? VS_ACT : ~VS_ACT;
      FRAME_START <= s1_fs;
      if (PIX_REQ && PIX_VALID) begin
        TX_RED <= PIX_RGB[23:16];
        TX_GRN <= PIX_RGB[15:8];
        TX_BLU <= PIX_RGB[7:0];
      end else begin
        TX_RED <= '0;
        TX_GRN <= '0;
        TX_BLU <= '0;
      end
    end
  end

  // sticky underflow; a set in the same cycle as a clear wins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      UNDERFLOW <= 1'b0;
    end else if (underflow_set_c) begin
      UNDERFLOW <= 1'b1;
    end else if (UNDERFLOW_CLR) begin
      UNDERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench for dvi_timing_ctrl using a small 8x6 raster (48 clocks/frame).
// k counts clock edges since the IDLE->RUN edge (k=0); outputs are sampled 1ns after each edge.
module tb_dvi_timing_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        PIX_REQ;
  logic        PIX_VALID;
  logic [23:0] PIX_RGB;
  logic [7:0]  TX_RED;
  logic [7:0]  TX_GRN;
  logic [7:0]  TX_BLU;
  logic        TX_HS;
  logic        TX_VS;
  logic        TX_DE;
  logic        FRAME_START;
  logic        BUSY;
  logic        UNDERFLOW;
  logic        UNDERFLOW_CLR;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          k;
  logic [23:0] src_cnt;

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_ACT(1'b0), .VS_ACT(1'b0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .PIX_REQ(PIX_REQ), .PIX_VALID(PIX_VALID), .PIX_RGB(PIX_RGB),
    .TX_RED(TX_RED), .TX_GRN(TX_GRN), .TX_BLU(TX_BLU),
    .TX_HS(TX_HS), .TX_VS(TX_VS), .TX_DE(TX_DE),
    .FRAME_START(FRAME_START), .BUSY(BUSY),
    .UNDERFLOW(UNDERFLOW), .UNDERFLOW_CLR(UNDERFLOW_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          k;
    logic        req;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input int kk, input logic r, input logic d, input logic h,
                              input logic v, input logic f, input logic [23:0] c);
    vec_t x;
    x.k = kk; x.req = r; x.de = d; x.hs = h; x.vs = v; x.fs = f; x.rgb = c;
    return x;
  endfunction

  function automatic logic [31:0] pack_out();
    return {2'b00, PIX_REQ, TX_DE, TX_HS, TX_VS, FRAME_START, BUSY, TX_RED, TX_GRN, TX_BLU};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (k=%0d)", name, act, exp, k);
    end
  endtask

  // one clock; the FWFT source pops only when a request meets a valid pixel
  task automatic tick();
    logic req_q;
    logic val_q;
    req_q = PIX_REQ;
    val_q = PIX_VALID;
    @(posedge CLK);
    #1;
    if (req_q && val_q) src_cnt = src_cnt + 24'd1;
    PIX_RGB = src_cnt;
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic restart();
    RESET = 1'b1; ENABLE = 1'b0; PIX_VALID = 1'b1; UNDERFLOW_CLR = 1'b0;
    src_cnt = 24'h000100; PIX_RGB = src_cnt;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0; ENABLE = 1'b1; k = -1;
  endtask

  initial begin
    int bad;
    // req, de, hs, vs, fs, rgb as seen 1ns after edge k
    tbl[0]  = mk(0,  0, 0, 1, 1, 0, 24'h0);
    tbl[1]  = mk(1,  1, 0, 1, 1, 0, 24'h0);
    tbl[2]  = mk(2,  1, 1, 1, 1, 1, 24'h100);
    tbl[3]  = mk(5,  0, 1, 1, 1, 0, 24'h103);
    tbl[4]  = mk(6,  0, 0, 1, 1, 0, 24'h0);
    tbl[5]  = mk(7,  0, 0, 0, 1, 0, 24'h0);
    tbl[6]  = mk(8,  0, 0, 0, 1, 0, 24'h0);
    tbl[7]  = mk(9,  1, 0, 1, 1, 0, 24'h0);
    tbl[8]  = mk(10, 1, 1, 1, 1, 0, 24'h104);
    tbl[9]  = mk(18, 1, 1, 1, 1, 0, 24'h108);
    tbl[10] = mk(21, 0, 1, 1, 1, 0, 24'h10B);
    tbl[11] = mk(26, 0, 0, 1, 1, 0, 24'h0);
    tbl[12] = mk(34, 0, 0, 1, 0, 0, 24'h0);
    tbl[13] = mk(39, 0, 0, 0, 0, 0, 24'h0);
    tbl[14] = mk(41, 0, 0, 1, 0, 0, 24'h0);
    tbl[15] = mk(42, 0, 0, 1, 1, 0, 24'h0);
    tbl[16] = mk(49, 1, 0, 1, 1, 0, 24'h0);
    tbl[17] = mk(50, 1, 1, 1, 1, 1, 24'h10C);
    tbl[18] = mk(98, 1, 1, 1, 1, 1, 24'h118);

    // reset state
    RESET = 1'b1; ENABLE = 1'b0; PIX_VALID = 1'b1; UNDERFLOW_CLR = 1'b0;
    src_cnt = 24'h000100; PIX_RGB = src_cnt; k = 0;
    @(posedge CLK); @(posedge CLK); #1;
    check("reset_outputs", {pack_out()[31:0]} | 32'(UNDERFLOW) << 31,
          {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});

    // continuous run, table of timing/data vectors
    restart();
    for (int i = 0; i < 19; i++) begin
      tick_to(tbl[i].k);
      check($sformatf("run_vec_k%0d", tbl[i].k), pack_out(),
            {2'b00, tbl[i].req, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, 1'b1, tbl[i].rgb});
    end

    // underflow: pixel (2,0) missing, then clear, then set+clear together
    restart();
    tick_to(3);
    PIX_VALID = 1'b0;
    tick();
    PIX_VALID = 1'b1;
    check("uf_black_pixel", {7'd0, TX_DE, TX_RED, TX_GRN, TX_BLU}, {7'd0, 1'b1, 24'h0});
    check("uf_flag_set", 32'(UNDERFLOW), 32'd1);
    tick();
    check("uf_no_retry_next_pixel", {8'd0, TX_RED, TX_GRN, TX_BLU}, 32'h00000102);
    check("uf_sticky", 32'(UNDERFLOW), 32'd1);
    UNDERFLOW_CLR = 1'b1;
    tick();
    UNDERFLOW_CLR = 1'b0;
    check("uf_cleared", 32'(UNDERFLOW), 32'd0);
    tick_to(9);
    PIX_VALID = 1'b0; UNDERFLOW_CLR = 1'b1;
    tick();
    PIX_VALID = 1'b1; UNDERFLOW_CLR = 1'b0;
    check("uf_set_beats_clr", 32'(UNDERFLOW), 32'd1);
    check("uf_black_line1", {7'd0, TX_DE, TX_RED, TX_GRN, TX_BLU}, {7'd0, 1'b1, 24'h0});

    // ENABLE dropped at clock 10: frame completes, then idle
    restart();
    tick_to(10);
    ENABLE = 1'b0;
    tick_to(18);
    check("stop_de_continues", 32'(TX_DE), 32'd1);
    tick_to(34);
    check("stop_vs_continues", 32'(TX_VS), 32'd0);
    tick_to(47);
    check("stop_last_hs_busy", {30'd0, TX_HS, BUSY}, {30'd0, 1'b0, 1'b1});
    tick();
    check("stop_busy_drops", 32'(BUSY), 32'd0);
    bad = 0;
    for (int i = 49; i <= 100; i++) begin
      tick();
      if (PIX_REQ || TX_DE || BUSY || FRAME_START || !TX_HS || !TX_VS) bad++;
    end
    check("stop_idle_quiet", 32'(bad), 32'd0);

    // ENABLE re-raised before the frame ends: no gap
    restart();
    tick_to(10);
    ENABLE = 1'b0;
    tick_to(30);
    ENABLE = 1'b1;
    bad = 0;
    for (int i = 31; i <= 60; i++) begin
      tick();
      if (!BUSY) bad++;
      if (k == 50) check("reraise_frame_start", {30'd0, FRAME_START, TX_DE}, 32'd3);
    end
    check("reraise_busy_continuous", 32'(bad), 32'd0);

    // asynchronous reset in the middle of an active line
    restart();
    tick_to(11);
    check("midline_de_before_reset", 32'(TX_DE), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("midline_reset_outputs", pack_out() | 32'(UNDERFLOW) << 31,
          {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    @(posedge CLK); #1;
    RESET = 1'b0; ENABLE = 1'b1; k = -1;
    src_cnt = 24'h000100; PIX_RGB = src_cnt;
    tick();
    check("restart_busy", 32'(BUSY), 32'd1);
    tick();
    check("restart_de_low_k1", 32'(TX_DE), 32'd0);
    tick();
    check("restart_de_k2", {30'd0, TX_DE, FRAME_START}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
